// File: rtl/nios_system_pkg.sv
// nios_system_pkg: register map constants and status packing for the from_sw command port
package nios_system_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;

    localparam int STAT_FULL   = 16;
    localparam int STAT_EMPTY  = 17;
    localparam int STAT_OVF    = 31;
    localparam int CTRL_FLUSH  = 0;
    localparam int CTRL_IRQ_EN = 1;

    function automatic logic [31:0] status_word(input logic [4:0] count, input logic full,
                                                input logic empty, input logic ovf);
        status_word = 32'(count);
        status_word[STAT_FULL] = full;
        status_word[STAT_EMPTY] = empty;
        status_word[STAT_OVF] = ovf;
    endfunction

endpackage

// File: rtl/nios_system_sync_fifo.sv
// nios_system_sync_fifo: circular command FIFO with occupancy count and flush
module nios_system_sync_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [4:0]            count,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wp;
    logic [AW-1:0]         rp;

    // storage only changes on an accepted push; contents are meaningless while empty
    always_ff @(posedge clk)
        if (push && !flush) mem[wp] <= wdata;

    // pointers and occupancy; flush overrides any same-cycle push or pop
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + 5'(push) - 5'(pop);
        end

    assign rdata = mem[rp];
    assign full  = count == 5'(DEPTH);
    assign empty = count == 5'd0;

endmodule

// File: rtl/nios_system_from_sw_cmd_port.sv
// nios_system_from_sw_cmd_port: Avalon-MM slave feeding software writes to a level port and a command FIFO
module nios_system_from_sw_cmd_port
    import nios_system_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    DEPTH       = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  irq
);
    logic        wr;
    logic        wr_data;
    logic        wr_ctrl;
    logic        pop;
    logic        push;
    logic        flush;
    logic        ovf_set;
    logic        ovf_clr;
    logic        overflow;
    logic        irq_en;
    logic        full;
    logic        empty;
    logic [4:0]  count;
    logic [31:0] rd_next;
    logic        unused_wdata;

    assign wr       = chipselect & ~write_n;
    assign wr_data  = wr && address == ADDR_DATA;
    assign wr_ctrl  = wr && address == ADDR_CONTROL;
    assign pop      = cmd_valid & cmd_ready;
    assign push     = wr_data && (!full || pop);
    assign flush    = wr_ctrl && writedata[CTRL_FLUSH];
    assign ovf_set  = wr_data && full && !pop;
    assign ovf_clr  = wr && address == ADDR_STATUS && writedata[STAT_OVF];
    assign cmd_valid = ~empty;
    assign unused_wdata = ^writedata;

    assign rd_next = address == ADDR_DATA    ? 32'(out_port) :
                     address == ADDR_STATUS  ? status_word(count, full, empty, overflow) :
                     address == ADDR_CONTROL ? {30'd0, irq_en, 1'b0} : '0;

    nios_system_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (writedata[DATA_WIDTH-1:0]),
        .rdata (cmd_data),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // software-visible registers; overflow set wins over a same-cycle clear
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            out_port <= RESET_VALUE;
            overflow <= 1'b0;
            irq_en <= 1'b0;
            irq <= 1'b0;
            readdata <= '0;
        end else begin
            if (wr_data) out_port <= writedata[DATA_WIDTH-1:0];
            if (wr_ctrl) irq_en <= writedata[CTRL_IRQ_EN];
            overflow <= ovf_set | (overflow & ~ovf_clr);
            irq <= irq_en & overflow;
            readdata <= rd_next;
        end

endmodule
